seg7_capture: RTL and testbench

- Display-side monitor for the seven-segment/digit-strobe interface produced by the counter/decoder display path. It reads that interface in the opposite direction.
- Samples the segment bus Y[6:0], the active-low digit enables dig1..dig4 and dp.
- Inverts the 4511-style decode back to BCD per digit position.
- Used as a loop-back checker on the board and as a self-check monitor in simulation.

---
 rtl/seg7_pkg.sv | 56 +++++
 rtl/seg7_stable_det.sv | 61 ++++++
 rtl/seg7_capture.sv | 100 ++++++++++
 tb/tb_seg7_capture.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns, sample layout and the
// inverse 4511-style decode used by the display-side capture monitor.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7C;
    localparam logic [6:0] SEG_6T    = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_9T    = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // dig_n[0] is dig1; digit enables stay active-low as sampled from the pins.
    typedef struct packed {
        logic [3:0] dig_n;
        logic       dp;
        logic [6:0] y;
    } sample_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] code;
    } bcd_t;

    function automatic bcd_t seg7_to_bcd(input logic [6:0] seg);
        bcd_t r;
        r.legal = 1'b1;
        r.blank = 1'b0;
        r.code  = BLANK_CODE;
        case (seg)
            SEG_0:          r.code = 4'd0;
            SEG_1:          r.code = 4'd1;
            SEG_2:          r.code = 4'd2;
            SEG_3:          r.code = 4'd3;
            SEG_4:          r.code = 4'd4;
            SEG_5:          r.code = 4'd5;
            SEG_6, SEG_6T:  r.code = 4'd6;
            SEG_7:          r.code = 4'd7;
            SEG_8:          r.code = 4'd8;
            SEG_9, SEG_9T:  r.code = 4'd9;
            SEG_BLANK:      r.blank = 1'b1;
            default:        r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_stable_det.sv
// Synchronizes the display pins and flags the single cycle in which a newly
// stable sample should be captured.
module seg7_stable_det
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CW            = 3
) (
    input  logic       CP,
    input  logic       MR,
    input  logic [6:0] y,
    input  logic [3:0] dig_n,
    input  logic       dp,
    output logic       cap_en,
    output sample_t    sample
);

    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

    sample_t       sync1;
    sample_t       sync2;
    sample_t       prev;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          same;
    logic          any_on;

    assign sample = sync2;
    assign same   = (sync2 == prev);
    assign any_on = ~&sync2.dig_n;
    assign cap_en = armed && same && (cnt == CNT_CAP) && any_on;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // this block samples pre-edge values, which keeps the synchronizer chain
    // and the prev/counter comparison one clean stage apart.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            sync1 <= {dig_n, dp, y};
            sync2 <= sync1;
            prev  <= sync2;
            if (!same) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
                // One capture per stable pattern; a change re-arms.
                if (cap_en)
                    armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Display-side monitor: reads the multiplexed seven-segment bus back into
// per-position BCD, flags illegal patterns and signals completed frames.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CW            = 3
) (
    input  logic        CP,
    input  logic        MR,
    input  logic [6:0]  Y,
    input  logic        dig1,
    input  logic        dig2,
    input  logic        dig3,
    input  logic        dig4,
    input  logic        dp,
    input  logic        clr,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  blank,
    output logic [3:0]  dvalid,
    output logic        cap,
    output logic        frame_done,
    output logic        err
);

    sample_t    sample;
    logic       cap_en;
    bcd_t       dec;
    logic [3:0] active;
    logic [3:0] mask;
    logic [3:0] mask_merged;

    seg7_stable_det #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CW            (CW)
    ) u_stable (
        .CP     (CP),
        .MR     (MR),
        .y      (Y),
        .dig_n  ({dig4, dig3, dig2, dig1}),
        .dp     (dp),
        .cap_en (cap_en),
        .sample (sample)
    );

    // NOTE: every signal driven here gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        dec         = seg7_to_bcd(sample.y);
        active      = ~sample.dig_n;
        mask_merged = (clr ? 4'b0000 : mask) | active;
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            digits     <= '0;
            dps        <= '0;
            blank      <= '0;
            dvalid     <= '0;
            cap        <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            mask       <= '0;
        end else begin
            cap        <= cap_en;
            frame_done <= 1'b0;

            if (clr) begin
                err    <= 1'b0;
                dvalid <= '0;
                mask   <= '0;
            end

            // Capture assignments come after clr so a coincident capture wins.
            if (cap_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (active[i]) begin
                        digits[i*4 +: 4] <= dec.code;
                        dps[i]           <= sample.dp;
                        blank[i]         <= dec.blank;
                        dvalid[i]        <= dec.legal;
                    end
                end
                if (!dec.legal)
                    err <= 1'b1;
                // Only legal captures count toward a frame.
                if (dec.legal) begin
                    if (mask_merged == 4'b1111) begin
                        frame_done <= 1'b1;
                        mask       <= '0;
                    end else begin
                        mask <= mask_merged;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: expected captures are queued when a pattern
// is driven and compared when the cap pulse appears.
module tb_seg7_capture;

    logic        CP = 1'b0;
    logic        MR;
    logic [6:0]  Y;
    logic        dig1, dig2, dig3, dig4;
    logic        dp;
    logic        clr;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  blank;
    logic [3:0]  dvalid;
    logic        cap;
    logic        frame_done;
    logic        err;

    seg7_capture #(.STABLE_CYCLES(4), .CW(3)) dut (
        .CP         (CP),
        .MR         (MR),
        .Y          (Y),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dig4       (dig4),
        .dp         (dp),
        .clr        (clr),
        .digits     (digits),
        .dps        (dps),
        .blank      (blank),
        .dvalid     (dvalid),
        .cap        (cap),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dps;
        logic [3:0]  blank;
        logic [3:0]  dvalid;
        logic        err;
        logic        frame_done;
    } exp_t;

    exp_t sb_q[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int cap_count = 0;

    logic [15:0] m_digits;
    logic [3:0]  m_dps, m_blank, m_dvalid, m_mask;
    logic        m_err;

    always @(negedge CP) if (cap === 1'b1) cap_count++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode, {legal, blank, code}.
    function automatic logic [5:0] ref_dec(input logic [6:0] y);
        case (y)
            7'h3F: return 6'h20;
            7'h06: return 6'h21;
            7'h5B: return 6'h22;
            7'h4F: return 6'h23;
            7'h66: return 6'h24;
            7'h6D: return 6'h25;
            7'h7C, 7'h7D: return 6'h26;
            7'h07: return 6'h27;
            7'h7F: return 6'h28;
            7'h67, 7'h6F: return 6'h29;
            7'h00: return 6'h3F;
            default: return 6'h0F;
        endcase
    endfunction

    task automatic model_reset();
        m_digits = '0; m_dps = '0; m_blank = '0; m_dvalid = '0; m_mask = '0; m_err = 1'b0;
    endtask

    task automatic model_clr();
        m_err = 1'b0; m_dvalid = '0; m_mask = '0;
    endtask

    task automatic model_capture(input logic [3:0] act, input logic [6:0] y,
                                 input logic dpv, input logic clr_now);
        logic [5:0] d;
        logic [3:0] nm;
        exp_t e;
        d = ref_dec(y);
        if (clr_now) model_clr();
        for (int i = 0; i < 4; i++) begin
            if (act[i]) begin
                m_digits[i*4 +: 4] = d[3:0];
                m_dps[i]    = dpv;
                m_blank[i]  = d[4];
                m_dvalid[i] = d[5];
            end
        end
        if (!d[5]) m_err = 1'b1;
        e.frame_done = 1'b0;
        if (d[5]) begin
            nm = m_mask | act;
            if (nm == 4'b1111) begin
                e.frame_done = 1'b1;
                m_mask = '0;
            end else begin
                m_mask = nm;
            end
        end
        e.digits = m_digits; e.dps = m_dps; e.blank = m_blank;
        e.dvalid = m_dvalid; e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] act, input logic [6:0] y, input logic dpv);
        {dig4, dig3, dig2, dig1} = ~act;
        Y  = y;
        dp = dpv;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    // Waits for cap, checks latency in edges (0 = skip) and the queued result.
    task automatic expect_capture(input string tag, input int lat_exp);
        int   edges;
        exp_t e;
        edges = 0;
        do begin
            @(posedge CP);
            #1;
            edges++;
        end while (cap !== 1'b1 && edges < 20);
        check({tag, ".cap"}, 16'(cap), 16'h1);
        if (lat_exp > 0) check({tag, ".latency"}, 16'(edges), 16'(lat_exp));
        if (sb_q.size() == 0) begin
            check({tag, ".queue"}, 16'h0, 16'h1);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".digits"},     digits,             e.digits);
            check({tag, ".dps"},        16'(dps),           16'(e.dps));
            check({tag, ".blank"},      16'(blank),         16'(e.blank));
            check({tag, ".dvalid"},     16'(dvalid),        16'(e.dvalid));
            check({tag, ".err"},        16'(err),           16'(e.err));
            check({tag, ".frame_done"}, 16'(frame_done),    16'(e.frame_done));
        end
    endtask

    initial begin
        logic [6:0] scan_y [4];
        int c0;
        scan_y[0] = 7'h06; scan_y[1] = 7'h5B; scan_y[2] = 7'h66; scan_y[3] = 7'h7F;

        MR  = 1'b1;
        clr = 1'b0;
        drive(4'b0000, 7'h00, 1'b0);
        model_reset();
        step(3);
        check("reset.digits", digits, 16'h0);
        check("reset.dvalid", 16'(dvalid), 16'h0);
        check("reset.cap",    16'(cap), 16'h0);
        check("reset.err",    16'(err), 16'h0);
        MR = 1'b0;
        step(3);

        // Warm-up capture so the asynchronous reset has something to clear.
        model_capture(4'b0001, 7'h06, 1'b0, 1'b0);
        drive(4'b0001, 7'h06, 1'b0);
        expect_capture("warm", 6);

        // Reset in the middle of a stability window.
        drive(4'b0010, 7'h5B, 1'b0);
        step(3);
        #3 MR = 1'b1;
        #1;
        check("mr.digits",     digits, 16'h0);
        check("mr.dps",        16'(dps), 16'h0);
        check("mr.blank",      16'(blank), 16'h0);
        check("mr.dvalid",     16'(dvalid), 16'h0);
        check("mr.cap",        16'(cap), 16'h0);
        check("mr.frame_done", 16'(frame_done), 16'h0);
        check("mr.err",        16'(err), 16'h0);
        model_reset();
        drive(4'b0001, 7'h4F, 1'b0);
        step(2);
        MR = 1'b0;
        c0 = cap_count;
        model_capture(4'b0001, 7'h4F, 1'b0, 1'b0);
        expect_capture("dig1_3", 6);
        step(4);
        check("dig1_3.cap_count", 16'(cap_count - c0), 16'h1);

        // Multiplexed scan 1,2,4,8.
        for (int i = 0; i < 4; i++) begin
            model_capture(4'(1 << i), scan_y[i], 1'b0, 1'b0);
            drive(4'(1 << i), scan_y[i], 1'b0);
            expect_capture($sformatf("scan%0d", i + 1), 6);
            step(2);
        end

        // Static drive of all four positions.
        model_capture(4'b1111, 7'h7C, 1'b1, 1'b0);
        drive(4'b1111, 7'h7C, 1'b1);
        expect_capture("static6", 6);
        step(2);
        model_capture(4'b1111, 7'h6F, 1'b1, 1'b0);
        drive(4'b1111, 7'h6F, 1'b1);
        expect_capture("static9", 6);
        step(2);

        // Glitching segment bus must never capture.
        c0 = cap_count;
        for (int k = 0; k < 10; k++) begin
            drive(4'b0001, (k % 2 == 0) ? 7'h06 : 7'h3F, 1'b0);
            step(2);
        end
        check("glitch.cap_count", 16'(cap_count - c0), 16'h0);
        c0 = cap_count;
        model_capture(4'b0001, 7'h06, 1'b0, 1'b0);
        drive(4'b0001, 7'h06, 1'b0);
        expect_capture("glitch_hold", 6);
        step(10);
        check("glitch_hold.cap_count", 16'(cap_count - c0), 16'h1);

        // Idle: blank bus, no digit enabled.
        c0 = cap_count;
        drive(4'b0000, 7'h00, 1'b0);
        step(12);
        check("idle.cap_count", 16'(cap_count - c0), 16'h0);
        check("idle.err",       16'(err), 16'(m_err));

        // Illegal pattern, clear, then blank on dig3.
        model_capture(4'b0010, 7'h49, 1'b0, 1'b0);
        drive(4'b0010, 7'h49, 1'b0);
        expect_capture("illegal", 6);
        step(2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        model_clr();
        check("clr.err",    16'(err), 16'(m_err));
        check("clr.dvalid", 16'(dvalid), 16'(m_dvalid));
        model_capture(4'b0100, 7'h00, 1'b0, 1'b0);
        drive(4'b0100, 7'h00, 1'b0);
        expect_capture("blank3", 6);
        step(2);

        // clr coincident with a dig1 capture, then a dig2/dig4/dig3 scan.
        model_capture(4'b0001, 7'h6D, 1'b0, 1'b1);
        drive(4'b0001, 7'h6D, 1'b0);
        step(5);
        clr = 1'b1;
        expect_capture("clr_cap", 1);
        clr = 1'b0;
        step(2);
        model_capture(4'b0010, 7'h5B, 1'b0, 1'b0);
        drive(4'b0010, 7'h5B, 1'b0);
        expect_capture("post_clr_dig2", 6);
        step(2);
        model_capture(4'b1000, 7'h07, 1'b0, 1'b0);
        drive(4'b1000, 7'h07, 1'b0);
        expect_capture("post_clr_dig4", 6);
        step(2);
        model_capture(4'b0100, 7'h4F, 1'b0, 1'b0);
        drive(4'b0100, 7'h4F, 1'b0);
        expect_capture("post_clr_dig3", 6);
        step(2);

        check("scoreboard.empty", 16'(sb_q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
